// File: rtl/ha_array_reducer.sv
// rtl/ha_array_reducer.sv - shift-accumulate reducer for the 8x8 HA-array multiplier rows
// Optional build macro: HA_REDUCE_SKIPZERO_EN (stop accumulating after the highest non-zero row)
module ha_array_reducer #(
   parameter int ROWS  = 4,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       ha_array_0_b,
   input  logic [6:0]       ha_array_1_b,
   input  logic [6:0]       ha_array_2_b,
   input  logic [6:0]       ha_array_3_b,
   input  logic [8:0]       ha_array_0_t,
   input  logic [8:0]       ha_array_1_t,
   input  logic [8:0]       ha_array_2_t,
   input  logic [8:0]       ha_array_3_t,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] product,
   output logic             ovf,
   output logic             busy
);

   localparam int ACC_W = OUT_W + 1;
   localparam int IDX_W = $clog2(ROWS);
   localparam int ROW_W = 10;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] last_idx;
   logic [6:0]       in_b [ROWS];
   logic [8:0]       in_t [ROWS];
   logic [6:0]       b_q  [ROWS];
   logic [8:0]       t_q  [ROWS];
   logic [ROW_W-1:0] row_val;
   logic [ACC_W-1:0] row_term;

   assign in_b[0] = ha_array_0_b;
   assign in_b[1] = ha_array_1_b;
   assign in_b[2] = ha_array_2_b;
   assign in_b[3] = ha_array_3_b;
   assign in_t[0] = ha_array_0_t;
   assign in_t[1] = ha_array_1_t;
   assign in_t[2] = ha_array_2_t;
   assign in_t[3] = ha_array_3_t;

   // handshake readiness and activity follow the state register alone
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

`ifdef HA_REDUCE_SKIPZERO_EN
   logic [IDX_W-1:0] top_row;

   // highest row index carrying any set bit; an all-zero bundle still runs row 0
   always_comb begin
      top_row = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (in_b[i] != '0 || in_t[i] != '0) top_row = IDX_W'(i);
      end
   end

   // remember where accumulation may stop for the bundle being accepted
   always_ff @(posedge clk) begin
      if (rst) last_idx <= '0;
      else if (state == IDLE && in_valid) last_idx <= top_row;
   end
`else
   assign last_idx = IDX_W'(ROWS - 1);
`endif

   // current row value R = t + (b << 2), placed at weight 4^idx
   always_comb begin
      row_val  = {1'b0, t_q[idx]} + {1'b0, b_q[idx], 2'b00};
      row_term = {{(ACC_W - ROW_W){1'b0}}, row_val} << {idx, 1'b0};
   end

   // capture the row bundle on the accepting handshake only
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         for (int i = 0; i < ROWS; i++) begin
            b_q[i] <= in_b[i];
            t_q[i] <= in_t[i];
         end
      end
   end

   // control FSM: accept, accumulate one row per cycle, present registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         product   <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc   <= '0;
                  idx   <= '0;
                  state <= ACC;
               end
            end
            ACC: begin
               acc <= acc + row_term;
               idx <= idx + 1'b1;
               if (idx == last_idx) state <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  product   <= acc[OUT_W-1:0];
                  ovf       <= acc[OUT_W];
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  product   <= '0;
                  ovf       <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ha_array_reducer.sv
// tb/tb_ha_array_reducer.sv - directed self-checking bench for ha_array_reducer
module tb_ha_array_reducer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [6:0]  b_in [4];
   logic [8:0]  t_in [4];
   logic        in_ready;
   logic        out_valid;
   logic [15:0] product;
   logic        ovf;
   logic        busy;

   int passed = 0;
   int total  = 0;
   int outs   = 0;
   int exp_q [$];

   always #5 clk = ~clk;

   ha_array_reducer #(.ROWS(4), .OUT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]),
      .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
      .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]),
      .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
      .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .ovf(ovf), .busy(busy)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // full-precision sum of all rows weighted by 4^i
   function automatic int model_sum();
      int s = 0;
      for (int i = 0; i < 4; i++) s += (int'(t_in[i]) + 4 * int'(b_in[i])) * (1 << (2 * i));
      return s;
   endfunction

   function automatic int exp_lat();
      int h = 0;
`ifdef HA_REDUCE_SKIPZERO_EN
      for (int i = 0; i < 4; i++) if (t_in[i] != 0 || b_in[i] != 0) h = i;
      return h + 2;
`else
      return 5;
`endif
   endfunction

   // scoreboard: push on accepted bundle, compare and pop on delivered product
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) chk("sb_unexpected_out", 1, 0);
            else begin
               chk("sb_product", int'(product), exp_q[0] % 65536);
               chk("sb_ovf", int'(ovf), int'(exp_q[0] >= 65536));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  outs++;
               end
            end
         end else begin
            chk("sb_idle_product", int'(product), 0);
            chk("sb_idle_ovf", int'(ovf), 0);
         end
         if (in_valid && in_ready) exp_q.push_back(model_sum());
      end
   end

   task automatic set_rows(input logic [35:0] tv, input logic [27:0] bv);
      for (int i = 0; i < 4; i++) begin
         t_in[i] = tv[9*i +: 9];
         b_in[i] = bv[7*i +: 7];
      end
   endtask

   task automatic send();
      int n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) chk("out_timeout", 0, 1);
   endtask

   task automatic do_txn(input string nm, input logic [35:0] tv, input logic [27:0] bv,
                         input int exp_p, input int exp_o);
      int lat;
      set_rows(tv, bv);
      chk({nm, "_model"}, model_sum(), exp_p + exp_o * 65536);
      send();
      wait_out(lat);
      chk({nm, "_latency"}, lat, exp_lat());
      chk({nm, "_product"}, int'(product), exp_p);
      chk({nm, "_ovf"}, int'(ovf), exp_o);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int base;
      int n;
      set_rows('0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_product", int'(product), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // row0 t=1 only
      do_txn("row0_one", 36'h000000001, 28'h0, 1, 0);
      // row3 at full scale: 1019 << 6
      do_txn("row3_full", {9'h1FF, 27'h0}, {7'h7F, 21'h0}, 65216, 0);
      // every row at full scale: 86615 wraps to 21079
      do_txn("all_full", {4{9'h1FF}}, {4{7'h7F}}, 21079, 1);
      // all-zero bundle
      do_txn("all_zero", 36'h0, 28'h0, 0, 0);

      // backpressure: row2 t=5,b=1 -> 9<<4 = 144, then row0 t=16,b=2 -> 24
      out_ready = 1'b0;
      set_rows({9'h0, 9'h005, 18'h0}, {7'h0, 7'h01, 14'h0});
      send();
      wait_out(lat);
      chk("bp_first_product", int'(product), 144);
      set_rows(36'h000000010, 28'h0000002);
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_product", int'(product), 144);
         chk("bp_hold_in_ready", int'(in_ready), 0);
         chk("bp_hold_out_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", int'(out_valid), 0);
      chk("bp_release_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_new_busy", int'(busy), 1);
      wait_out(lat);
      chk("bp_new_latency", lat, exp_lat());
      chk("bp_new_product", int'(product), 24);
      @(posedge clk); #1;

      // reset during the second accumulate cycle
      set_rows({4{9'h001}}, 28'h0);
      send();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_product", int'(product), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      do_txn("after_rst", {18'h0, 9'h003, 9'h0}, 28'h0, 12, 0);

      // back-to-back bundles with downstream always ready
      base = outs;
      for (int k = 0; k < 4; k++) begin
         set_rows({9'(k * 3), 9'(k + 7), 9'(40 * k), 9'(k + 1)},
                  {7'(k), 7'h0, 7'(k * 5), 7'(k + 2)});
         send();
      end
      n = 0;
      while (outs < base + 4 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b_count", outs - base, 4);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
